rx_rate_monitor: RTL and testbench
==================================

Name: rx_rate_monitor

Overview:
Parametrised multi-channel receive-statistics monitor for the clk125MHz domain. It is the generalised successor to the single one-second enable counter in the receive top level. Per channel it counts data bytes, completed frames and errored frames over a programmable measurement window. At each window boundary it latches a coherent snapshot for the VIO/status path, in free-running, one-shot or accumulate mode.

Parameters:
NCH, 2, number of monitored byte streams (e.g. raw PHY output, post-majority output)
CNT_W, 32, width of every counter and snapshot field
WINDOW_CYCLES, 125000000, window length in clk125MHz cycles (1 s); must be >= 4
TMR_W, 27, width of the window timer; must satisfy 2^TMR_W >= WINDOW_CYCLES

Ports:
clk125MHz  in  1  system clock
RST  in  1  reset, synchronous, active-high
en  in  NCH  per-channel byte-valid (one byte per cycle while high)
err  in  NCH  per-channel error flag; sampled only when the matching en bit is high
mode  in  2  0 = free-running, 1 = one-shot, 2 = accumulate; 3 is reserved and behaves as 0
clr  in  1  single-cycle pulse: clear running counters and timer
arm  in  1  single-cycle pulse: start a one-shot window (mode 1 only)
bytes_snap  out  NCH*CNT_W  latched byte counts; channel k at [k*CNT_W +: CNT_W]
frames_snap  out  NCH*CNT_W  latched completed-frame counts
errfr_snap  out  NCH*CNT_W  latched errored-frame counts
snap_valid  out  1  one-cycle pulse in the cycle after the snapshot registers update
snap_seq  out  16  snapshot sequence number; increments at each latch and wraps at 0xFFFF -> 0
busy  out  1  high while a window is timing

Behaviour:
- Reset: all running counters, snapshots, snap_seq, timer, per-channel en_d and err_seen are 0. snap_valid = 0.
- Reset state: busy = 1 in modes 0 and 2; busy = 0 in mode 1 (IDLE).
- Controller FSM states: IDLE, RUN, LATCH.
  - Modes 0 and 2 leave reset directly into RUN.
  - Mode 1: IDLE -> RUN on arm.
  - RUN -> LATCH when timer == WINDOW_CYCLES-1.
  - LATCH lasts one cycle, then goes to RUN (modes 0 and 2) or IDLE (mode 1).
- Timer:
  - increments by 1 each RUN cycle;
  - returns to 0 on entering LATCH;
  - holds 0 in IDLE.
  - The window is exactly WINDOW_CYCLES RUN cycles.
- Byte counting:
  - the counter increments in every RUN cycle with en[k] = 1, including the final window cycle;
  - in LATCH and IDLE, bytes are not counted.
- Frame detection per channel:
  - frame start = en & ~en_d; frame end = ~en & en_d; en_d is registered every cycle in all states.
  - err_seen is set by (en & err) and cleared at frame end.
  - At frame end, frames += 1. If err_seen, or err is asserted in that same en-high cycle, errfr += 1.
  - A frame is attributed to the window in which its end falls.
  - A frame end landing in LATCH is held pending and applied in the first RUN cycle that follows. Nothing is lost.
- Saturation: every counter saturates at 2^CNT_W-1 and never wraps.
- LATCH:
  - the snapshots load the running values, which include the final RUN cycle;
  - snap_seq increments;
  - snap_valid pulses on the next cycle;
  - in modes 0 and 1, the running counters clear to 0;
  - in mode 2, the running counters keep accumulating.
- clr pulse:
  - running counters, timer and pending flags go to 0; snapshots are untouched;
  - clr together with the boundary cycle: clr wins, so there is no latch and no snap_valid;
  - in mode 1, clr aborts a RUN window and returns to IDLE.
- arm:
  - ignored in RUN and LATCH, and in modes 0 and 2;
  - arm together with clr in IDLE: clr first, and the window does not start.
- mode changes take effect only from IDLE, or at the next LATCH.
- Latency: the snapshot is visible 1 cycle after the boundary cycle; snap_valid follows 1 cycle after that.

Decomposition:
- Package rx_mon_pkg:
  - mode encodings MODE_FREE, MODE_ONESHOT, MODE_ACCUM;
  - FSM state typedef;
  - saturating-increment function.
- Sub-module rx_rate_chan, instantiated NCH times via generate:
  - contains en_d, err_seen, pending-end flag, three saturating counters and three snapshot registers;
  - takes count_en, latch, clear_run and clr as controls from the top-level FSM.

Test Plan (WINDOW_CYCLES=100, CNT_W=16, NCH=2):
- Mode 0, en[0] high for 30 cycles starting at timer 10, no err -> snapshot ch0 bytes=30, frames=1, errfr=0; ch1 all 0; snap_valid at cycle 101; snap_seq=1.
- Frame on ch1 from timer 95 to timer 4 of the next window -> window 1: bytes=5, frames=0; window 2: bytes=5, frames=1.
- A frame end falling exactly in the LATCH cycle -> the frame is counted in the next window's frames; errfr is incremented there if err was asserted in-frame.
- Mode 1: arm, then 3 frames of 10 bytes on ch0, one with err -> single snapshot bytes=30, frames=3, errfr=1; busy falls; no further snap_valid without a new arm.
- Mode 2 over 3 windows, 20 bytes/window -> bytes_snap reads 20, 40, 60; snap_seq reads 1, 2, 3.
- Saturation: with CNT_W forced to 4, en held high for 40 cycles -> bytes_snap=15. clr pulsed together with the boundary cycle -> no snap_valid, and the next window starts from 0.

Source files
------------

// File: rtl/rx_rate_monitor_pkg.sv
// Shared types and helpers for the multi-channel receive-rate monitor.
package rx_mon_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_ACCUM   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam int unsigned SEQ_W = 16;

    // Add a 0..2 increment to a w-bit counter, clamping at 2^w-1.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [1:0] inc,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] maxv;
        maxv = (65'd1 << w) - 65'd1;
        sum  = {1'b0, v} + {63'd0, inc};
        return (sum > maxv) ? maxv[63:0] : sum[63:0];
    endfunction

    // The reserved encoding behaves as free-running.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_FREE : mode_e'(m);
    endfunction

endpackage

// File: rtl/rx_rate_monitor_if.sv
// Control/status bundle between the receive path and the rate monitor.
interface rx_rate_monitor_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 32
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       err;
    logic [1:0]           mode;
    logic                 clr;
    logic                 arm;
    logic [NCH*CNT_W-1:0] bytes_snap;
    logic [NCH*CNT_W-1:0] frames_snap;
    logic [NCH*CNT_W-1:0] errfr_snap;
    logic                 snap_valid;
    logic [15:0]          snap_seq;
    logic                 busy;

    modport master (
        output en, err, mode, clr, arm,
        input  bytes_snap, frames_snap, errfr_snap, snap_valid, snap_seq, busy
    );

    modport slave (
        input  en, err, mode, clr, arm,
        output bytes_snap, frames_snap, errfr_snap, snap_valid, snap_seq, busy
    );
endinterface

// File: rtl/rx_rate_monitor_chan.sv
// One monitored byte stream: frame detection, saturating counters and snapshot registers.
module rx_rate_chan
    import rx_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk125MHz,
    input  logic             RST,
    input  logic             en,
    input  logic             err,
    input  logic             count_en,
    input  logic             latch,
    input  logic             clear_run,
    input  logic             pend_en,
    input  logic             clr,
    output logic [CNT_W-1:0] bytes_snap,
    output logic [CNT_W-1:0] frames_snap,
    output logic [CNT_W-1:0] errfr_snap
);

    logic             en_d, err_seen, pend_f, pend_e, fe;
    logic [1:0]       b_inc, f_inc, e_inc;
    logic [CNT_W-1:0] bytes_q, frames_q, errfr_q;
    logic [CNT_W-1:0] bytes_nx, frames_nx, errfr_nx;

    // A pending end (from the latch cycle) and a fresh end can coincide after a long idle.
    always_comb begin
        fe        = ~en & en_d;
        b_inc     = {1'b0, en & count_en};
        f_inc     = count_en ? ({1'b0, fe} + {1'b0, pend_f}) : 2'd0;
        e_inc     = count_en ? ({1'b0, fe & err_seen} + {1'b0, pend_e}) : 2'd0;
        bytes_nx  = CNT_W'(sat_inc(64'(bytes_q),  b_inc, CNT_W));
        frames_nx = CNT_W'(sat_inc(64'(frames_q), f_inc, CNT_W));
        errfr_nx  = CNT_W'(sat_inc(64'(errfr_q),  e_inc, CNT_W));
    end

    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            en_d        <= 1'b0;
            err_seen    <= 1'b0;
            pend_f      <= 1'b0;
            pend_e      <= 1'b0;
            bytes_q     <= '0;
            frames_q    <= '0;
            errfr_q     <= '0;
            bytes_snap  <= '0;
            frames_snap <= '0;
            errfr_snap  <= '0;
        end else begin
            en_d <= en;
            if (fe)
                err_seen <= 1'b0;
            else if (en && err)
                err_seen <= 1'b1;

            if (clr) begin
                pend_f <= 1'b0;
                pend_e <= 1'b0;
            end else if (pend_en && fe) begin
                pend_f <= 1'b1;
                pend_e <= err_seen;
            end else if (count_en) begin
                pend_f <= 1'b0;
                pend_e <= 1'b0;
            end

            if (clr || clear_run) begin
                bytes_q  <= '0;
                frames_q <= '0;
                errfr_q  <= '0;
            end else begin
                bytes_q  <= bytes_nx;
                frames_q <= frames_nx;
                errfr_q  <= errfr_nx;
            end

            if (latch) begin
                bytes_snap  <= bytes_nx;
                frames_snap <= frames_nx;
                errfr_snap  <= errfr_nx;
            end
        end
    end

endmodule

// File: rtl/rx_rate_monitor.sv
// Window controller for the per-channel receive statistics; drives NCH rx_rate_chan slices.
module rx_rate_monitor
    import rx_mon_pkg::*;
#(
    parameter int unsigned NCH           = 2,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned WINDOW_CYCLES = 125000000,
    parameter int unsigned TMR_W         = 27
) (
    input  logic             clk125MHz,
    input  logic             RST,
    rx_rate_monitor_if.slave mon
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);

    state_e               state, state_nx;
    mode_e                mode_q, mode_in, mode_eff;
    logic [TMR_W-1:0]     timer, timer_nx;
    logic                 count_en_c, latch_c, clear_run_c, pend_en_c;
    logic                 busy_q, snap_valid_q;
    logic [SEQ_W-1:0]     seq_q;
    logic [NCH*CNT_W-1:0] bytes_all, frames_all, errfr_all;

    // Next state, timer and channel controls; clr beats the window boundary.
    always_comb begin
        mode_in     = norm_mode(mon.mode);
        mode_eff    = (state == ST_RUN) ? mode_q : mode_in;
        state_nx    = state;
        timer_nx    = '0;
        count_en_c  = 1'b0;
        latch_c     = 1'b0;
        clear_run_c = 1'b0;
        pend_en_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mon.clr && (mode_eff != MODE_ONESHOT || mon.arm))
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                count_en_c = 1'b1;
                if (mon.clr) begin
                    if (mode_q == MODE_ONESHOT)
                        state_nx = ST_IDLE;
                end else if (timer == TMR_LAST) begin
                    state_nx    = ST_LATCH;
                    latch_c     = 1'b1;
                    clear_run_c = (mode_q != MODE_ACCUM);
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_LATCH: begin
                pend_en_c = 1'b1;
                state_nx  = (mode_eff == MODE_ONESHOT) ? ST_IDLE : ST_RUN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Mode is only sampled outside a running window.
    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            state        <= (mode_in == MODE_ONESHOT) ? ST_IDLE : ST_RUN;
            mode_q       <= mode_in;
            timer        <= '0;
            busy_q       <= (mode_in != MODE_ONESHOT);
            snap_valid_q <= 1'b0;
            seq_q        <= '0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            busy_q       <= (state_nx != ST_IDLE);
            snap_valid_q <= (state == ST_LATCH);
            if (state != ST_RUN)
                mode_q <= mode_in;
            if (latch_c)
                seq_q <= seq_q + 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        rx_rate_chan #(.CNT_W(CNT_W)) u_chan (
            .clk125MHz   (clk125MHz),
            .RST         (RST),
            .en          (mon.en[k]),
            .err         (mon.err[k]),
            .count_en    (count_en_c),
            .latch       (latch_c),
            .clear_run   (clear_run_c),
            .pend_en     (pend_en_c),
            .clr         (mon.clr),
            .bytes_snap  (bytes_all[k*CNT_W +: CNT_W]),
            .frames_snap (frames_all[k*CNT_W +: CNT_W]),
            .errfr_snap  (errfr_all[k*CNT_W +: CNT_W])
        );
    end

    assign mon.bytes_snap  = bytes_all;
    assign mon.frames_snap = frames_all;
    assign mon.errfr_snap  = errfr_all;
    assign mon.snap_valid  = snap_valid_q;
    assign mon.snap_seq    = seq_q;
    assign mon.busy        = busy_q;

endmodule

// File: tb/tb_rx_rate_monitor.sv
// Randomised/directed bench: a 16-bit and a 4-bit monitor share stimulus; expectations come from an input log.
module tb_rx_rate_monitor;

    localparam int unsigned NCH   = 2;
    localparam int unsigned WIN   = 100;
    localparam int unsigned PER   = WIN + 1;
    localparam int unsigned TMR_W = 7;
    localparam int unsigned CW_A  = 16;
    localparam int unsigned CW_B  = 4;
    localparam int          MAXC  = 2048;

    logic clk125MHz = 1'b0;
    logic RST;
    always #4 clk125MHz = ~clk125MHz;

    rx_rate_monitor_if #(.NCH(NCH), .CNT_W(CW_A)) mon_a ();
    rx_rate_monitor_if #(.NCH(NCH), .CNT_W(CW_B)) mon_b ();

    rx_rate_monitor #(.NCH(NCH), .CNT_W(CW_A), .WINDOW_CYCLES(WIN), .TMR_W(TMR_W)) dut_a (
        .clk125MHz (clk125MHz),
        .RST       (RST),
        .mon       (mon_a)
    );

    rx_rate_monitor #(.NCH(NCH), .CNT_W(CW_B), .WINDOW_CYCLES(WIN), .TMR_W(TMR_W)) dut_b (
        .clk125MHz (clk125MHz),
        .RST       (RST),
        .mon       (mon_b)
    );

    assign mon_b.en   = mon_a.en;
    assign mon_b.err  = mon_a.err;
    assign mon_b.mode = mon_a.mode;
    assign mon_b.clr  = mon_a.clr;
    assign mon_b.arm  = mon_a.arm;

    logic [NCH-1:0] en_log  [0:MAXC-1];
    logic [NCH-1:0] err_log [0:MAXC-1];
    longint         exp_b [NCH];
    longint         exp_f [NCH];
    longint         exp_e [NCH];
    int             cyc = 0;
    int             checks = 0;
    int             failures = 0;

    task automatic tick();
        if (cyc < MAXC) begin
            en_log[cyc]  = mon_a.en;
            err_log[cyc] = mon_a.err;
        end
        @(posedge clk125MHz);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic bit is_end(input int ch, input int k);
        return (k > 0) && !en_log[k][ch] && en_log[k-1][ch];
    endfunction

    function automatic bit frame_had_err(input int ch, input int k);
        for (int j = k - 1; j >= 0 && en_log[j][ch]; j--)
            if (err_log[j][ch]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clr();
        for (int ch = 0; ch < NCH; ch++) begin
            exp_b[ch] = 0; exp_f[ch] = 0; exp_e[ch] = 0;
        end
    endtask

    // Add one window: bytes over its RUN cycles, frames whose end lies there or in the previous latch cycle.
    task automatic model_add(input int f, input int l, input int lp);
        for (int ch = 0; ch < NCH; ch++) begin
            for (int k = f; k <= l; k++) begin
                exp_b[ch] += longint'(en_log[k][ch]);
                if (is_end(ch, k)) begin
                    exp_f[ch]++;
                    if (frame_had_err(ch, k)) exp_e[ch]++;
                end
            end
            if (lp >= 0 && is_end(ch, lp)) begin
                exp_f[ch]++;
                if (frame_had_err(ch, lp)) exp_e[ch]++;
            end
        end
    endtask

    task automatic check_snap(input string tag);
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("%s_a_bytes%0d", tag, ch),  64'(mon_a.bytes_snap[ch*CW_A +: CW_A]),  sat(exp_b[ch], CW_A));
            chk($sformatf("%s_a_frames%0d", tag, ch), 64'(mon_a.frames_snap[ch*CW_A +: CW_A]), sat(exp_f[ch], CW_A));
            chk($sformatf("%s_a_errfr%0d", tag, ch),  64'(mon_a.errfr_snap[ch*CW_A +: CW_A]),  sat(exp_e[ch], CW_A));
            chk($sformatf("%s_b_bytes%0d", tag, ch),  64'(mon_b.bytes_snap[ch*CW_B +: CW_B]),  sat(exp_b[ch], CW_B));
            chk($sformatf("%s_b_frames%0d", tag, ch), 64'(mon_b.frames_snap[ch*CW_B +: CW_B]), sat(exp_f[ch], CW_B));
            chk($sformatf("%s_b_errfr%0d", tag, ch),  64'(mon_b.errfr_snap[ch*CW_B +: CW_B]),  sat(exp_e[ch], CW_B));
        end
    endtask

    task automatic check_ctl(input string tag, input bit valid, input int seq, input bit busy);
        chk({tag, "_a_valid"}, 64'(mon_a.snap_valid), 64'(valid));
        chk({tag, "_b_valid"}, 64'(mon_b.snap_valid), 64'(valid));
        chk({tag, "_a_seq"},   64'(mon_a.snap_seq),   64'(seq));
        chk({tag, "_b_seq"},   64'(mon_b.snap_seq),   64'(seq));
        chk({tag, "_a_busy"},  64'(mon_a.busy),       64'(busy));
        chk({tag, "_b_busy"},  64'(mon_b.busy),       64'(busy));
    endtask

    task automatic do_reset(input logic [1:0] m);
        mon_a.mode = m;
        mon_a.en   = '0;
        mon_a.err  = '0;
        mon_a.clr  = 1'b0;
        mon_a.arm  = 1'b0;
        RST        = 1'b1;
        tick();
        tick();
        model_clr();
        check_snap("rst");
        check_ctl("rst", 1'b0, 0, (m != 2'd1));
        RST = 1'b0;
    endtask

    function automatic logic rnd_en();
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic rnd_err();
        return ($urandom_range(0, 15) == 0);
    endfunction

    int s, t, j, seq_exp;
    bit rw;

    initial begin
        // Free-running: directed frames in windows 0-1, random traffic in windows 2-3.
        do_reset(2'd0);
        s = cyc;
        for (int k = 0; k < 5 * PER; k++) begin
            t  = k % PER;
            rw = (k >= 202 && k < 403);
            mon_a.en[0]  = (k >= 10 && k < 40) || (k >= 191 && k < 201) || (rw && rnd_en());
            mon_a.en[1]  = (k >= 95 && k < 106) || (rw && rnd_en());
            mon_a.err[0] = rw ? rnd_err() : (k == 195);
            mon_a.err[1] = rw ? rnd_err() : 1'b0;
            tick();
            if (t == WIN - 1) begin
                j = k / PER;
                model_clr();
                model_add(s + k - 99, s + k, (j > 0) ? s + k - 100 : -1);
                check_snap($sformatf("free_w%0d", j));
                chk($sformatf("free_w%0d_seq", j), 64'(mon_a.snap_seq), 64'(j + 1));
                if (j == 0) begin
                    chk("free_w0_ch0_bytes_lit",  64'(mon_a.bytes_snap[0 +: CW_A]),  64'd30);
                    chk("free_w0_ch0_frames_lit", 64'(mon_a.frames_snap[0 +: CW_A]), 64'd1);
                    chk("free_w0_ch1_bytes_lit",  64'(mon_a.bytes_snap[CW_A +: CW_A]), 64'd5);
                end else if (j == 1) begin
                    chk("free_w1_ch0_frames_lit", 64'(mon_a.frames_snap[0 +: CW_A]), 64'd0);
                    chk("free_w1_ch1_bytes_lit",  64'(mon_a.bytes_snap[CW_A +: CW_A]), 64'd5);
                end
            end
            chk($sformatf("free_k%0d_valid", k), 64'(mon_a.snap_valid), 64'(t == WIN));
            chk($sformatf("free_k%0d_busy", k),  64'(mon_b.busy), 64'd1);
        end

        // One-shot: idle (with clr+arm collision), a single armed window, then silence.
        do_reset(2'd1);
        for (int k = 0; k < 8; k++) begin
            mon_a.en[0] = (k >= 1 && k < 4);
            mon_a.clr   = (k == 5);
            mon_a.arm   = (k == 5);
            tick();
            check_ctl($sformatf("os_idle%0d", k), 1'b0, 0, 1'b0);
        end
        mon_a.arm = 1'b1;
        mon_a.clr = 1'b0;
        tick();
        chk("os_arm_busy", 64'(mon_a.busy), 64'd1);
        mon_a.arm = 1'b0;
        s = cyc;
        for (int k = 0; k <= WIN; k++) begin
            mon_a.en[0]  = (k >= 5 && k < 15) || (k >= 30 && k < 40) || (k >= 60 && k < 70);
            mon_a.err[0] = (k == 33);
            mon_a.arm    = (k == 50);
            tick();
            if (k == WIN - 1) begin
                model_clr();
                model_add(s, s + WIN - 1, -1);
                check_snap("os_win");
                chk("os_bytes_lit",  64'(mon_a.bytes_snap[0 +: CW_A]),  64'd30);
                chk("os_frames_lit", 64'(mon_a.frames_snap[0 +: CW_A]), 64'd3);
                chk("os_errfr_lit",  64'(mon_a.errfr_snap[0 +: CW_A]),  64'd1);
            end
            check_ctl($sformatf("os_run%0d", k), (k == WIN), (k >= WIN - 1) ? 1 : 0, (k < WIN));
        end
        mon_a.arm = 1'b0;
        for (int k = 0; k < 40; k++) begin
            mon_a.en[0] = (k >= 10 && k < 20);
            tick();
            check_ctl($sformatf("os_after%0d", k), 1'b0, 1, 1'b0);
        end

        // Accumulate: three windows of 20 bytes, clr on the 4th boundary, then a fresh window.
        do_reset(2'd2);
        s = cyc;
        model_clr();
        seq_exp = 0;
        for (int k = 0; k < 504; k++) begin
            t = (k < 403) ? (k % PER) : (k - 403);
            mon_a.en[0]  = (t >= 20 && t < 40);
            mon_a.en[1]  = (k < 500) && rnd_en();
            mon_a.err[0] = 1'b0;
            mon_a.err[1] = rnd_err();
            mon_a.clr    = (k == 402);
            tick();
            if (k < 402 && t == WIN - 1) begin
                j = k / PER;
                seq_exp = j + 1;
                model_add(s + k - 99, s + k, (j > 0) ? s + k - 100 : -1);
                check_snap($sformatf("acc_w%0d", j));
                chk($sformatf("acc_w%0d_bytes_lit", j), 64'(mon_a.bytes_snap[0 +: CW_A]), 64'(20 * (j + 1)));
                chk($sformatf("acc_w%0d_sat_lit", j),   64'(mon_b.bytes_snap[0 +: CW_B]), 64'd15);
            end
            if (k == 403) check_snap("acc_clr_hold");
            if (k == 502) begin
                seq_exp = 4;
                model_clr();
                model_add(s + 403, s + 502, -1);
                check_snap("acc_after_clr");
                chk("acc_after_clr_bytes_lit", 64'(mon_a.bytes_snap[0 +: CW_A]), 64'd20);
            end
            check_ctl($sformatf("acc_k%0d", k),
                      (k == 100 || k == 201 || k == 302 || k == 503), seq_exp, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
